// File: rtl/dispatch_buffer_pkg.sv
// Shared scheduler types: default dispatch payload, issue-queue selectors and
// width helpers for circular-buffer pointers and occupancy counters.
package dispatch_buffer_pkg;

    typedef logic [31:0] payload_t;

    typedef enum logic [1:0] {
        IQ_INT = 2'd0,
        IQ_MEM = 2'd1,
        IQ_FP  = 2'd2,
        IQ_BR  = 2'd3
    } iq_sel_e;

    typedef struct packed {
        logic    valid;
        iq_sel_e sel;
        logic [5:0] tag;
    } iq_hdr_t;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // One extra bit so a completely full buffer is distinguishable from empty.
    function automatic int cnt_width(input int depth);
        return ptr_width(depth) + 1;
    endfunction

endpackage

// File: rtl/dispatch_buffer_loc.sv
// Leading-ones counter: length of the unbroken run of set bits starting at bit 0.
module leading_ones_count #(
    parameter  int WIDTH = 2,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [CNT_W-1:0] count_o
);

    logic run;

    always_comb begin
        count_o = '0;
        run     = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            run = run & vec_i[i];
            if (run) begin
                count_o = count_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/dispatch_buffer.sv
// In-order dispatch buffer between rename and the issue-queue write ports:
// accepts whole rename groups, drains up to OUT_PORTS oldest entries per cycle.
module dispatch_buffer
    import dispatch_buffer_pkg::*;
#(
    parameter int  QUEUE_SIZE = 8,
    parameter int  IN_WIDTH   = 2,
    parameter int  OUT_PORTS  = 2,
    parameter type DATA_TYPE  = payload_t
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_i,
    input  logic [IN_WIDTH-1:0]  in_valid_i,
    output logic                 in_ready_o,
    input  DATA_TYPE             in_data_i [IN_WIDTH],
    output logic [OUT_PORTS-1:0] write_valid_o,
    input  logic [OUT_PORTS-1:0] write_ready_i,
    output DATA_TYPE             write_data_o [OUT_PORTS]
);

    localparam int PTR_W  = ptr_width(QUEUE_SIZE);
    localparam int CNT_W  = cnt_width(QUEUE_SIZE);
    localparam int IN_CW  = $clog2(IN_WIDTH + 1);
    localparam int OUT_CW = $clog2(OUT_PORTS + 1);

    DATA_TYPE         mem_q [QUEUE_SIZE];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [IN_CW-1:0]     push_cnt;
    logic [OUT_CW-1:0]    pop_cnt;
    logic [OUT_PORTS-1:0] port_fire;
    logic                 push_en;

    leading_ones_count #(.WIDTH(IN_WIDTH)) u_push_cnt (
        .vec_i   (in_valid_i),
        .count_o (push_cnt)
    );

    // A stalled port blocks every younger port behind it, keeping pops in order.
    assign port_fire = write_valid_o & write_ready_i;

    leading_ones_count #(.WIDTH(OUT_PORTS)) u_pop_cnt (
        .vec_i   (port_fire),
        .count_o (pop_cnt)
    );

    // Credit comes only from registered occupancy; same-cycle pops do not help.
    assign in_ready_o = (count_q <= CNT_W'(QUEUE_SIZE - IN_WIDTH));
    assign push_en    = in_ready_o && (push_cnt != '0) && !flush_i;

    for (genvar k = 0; k < OUT_PORTS; k++) begin : g_port
        assign write_valid_o[k] = (count_q > CNT_W'(k)) && !flush_i;
        assign write_data_o[k]  = mem_q[head_q + PTR_W'(k)];
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PTR_W'(pop_cnt);
            if (push_en) begin
                tail_d = tail_q + PTR_W'(push_cnt);
            end
            count_d = count_q + (push_en ? CNT_W'(push_cnt) : '0) - CNT_W'(pop_cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage is deliberately left unreset; only occupancy is cleared.
    always_ff @(posedge clk) begin
        if (push_en) begin
            for (int i = 0; i < IN_WIDTH; i++) begin
                if (in_valid_i[i]) begin
                    mem_q[tail_q + PTR_W'(i)] <= in_data_i[i];
                end
            end
        end
    end

    assert property (@(posedge clk) disable iff (rst)
                     (in_valid_i & (in_valid_i + IN_WIDTH'(1))) == '0)
        else $error("in_valid_i is not a contiguous prefix: %b", in_valid_i);

endmodule

// File: tb/tb_dispatch_buffer.sv
// Directed bench for dispatch_buffer: table of per-cycle vectors plus
// hand-written wrap, flush and mid-run reset sequences.
module tb_dispatch_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic [1:0]  in_valid_i;
    logic        in_ready_o;
    logic [31:0] in_data_i [2];
    logic [1:0]  write_valid_o;
    logic [1:0]  write_ready_i;
    logic [31:0] write_data_o [2];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dispatch_buffer #(
        .QUEUE_SIZE (8),
        .IN_WIDTH   (2),
        .OUT_PORTS  (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush_i),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .in_data_i     (in_data_i),
        .write_valid_o (write_valid_o),
        .write_ready_i (write_ready_i),
        .write_data_o  (write_data_o)
    );

    typedef struct {
        logic [1:0]  vld;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  rdy;
        logic        fl;
        logic [1:0]  ewv;
        logic [31:0] e0;
        logic [31:0] e1;
        logic        eir;
        int          ecnt;
    } vec_t;

    vec_t vecs [23];

    function automatic vec_t mk(logic [1:0] vld, logic [31:0] d0, logic [31:0] d1,
                                logic [1:0] rdy, logic fl, logic [1:0] ewv,
                                logic [31:0] e0, logic [31:0] e1, logic eir, int ecnt);
        vec_t v;
        v.vld = vld; v.d0 = d0; v.d1 = d1; v.rdy = rdy; v.fl = fl;
        v.ewv = ewv; v.e0 = e0; v.e1 = e1; v.eir = eir; v.ecnt = ecnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] vld, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [1:0] rdy, input logic fl);
        in_valid_i    = vld;
        in_data_i[0]  = d0;
        in_data_i[1]  = d1;
        write_ready_i = rdy;
        flush_i       = fl;
    endtask

    // Compare outputs for the current cycle; data only where the port is valid.
    task automatic check_cycle(input string tag, input logic [1:0] ewv, input logic [31:0] e0,
                               input logic [31:0] e1, input logic eir, input int ecnt);
        chk({tag, ".wvalid"}, {30'd0, write_valid_o}, {30'd0, ewv});
        chk({tag, ".in_ready"}, {31'd0, in_ready_o}, {31'd0, eir});
        chk({tag, ".count"}, {28'd0, dut.count_q}, ecnt);
        if (ewv[0]) chk({tag, ".data0"}, write_data_o[0], e0);
        if (ewv[1]) chk({tag, ".data1"}, write_data_o[1], e1);
    endtask

    initial begin
        // Reset, group push/hold/partial pop, fill to full with rejected pushes, wrap drain, flush
        vecs[0]  = mk(2'b11, 32'hA, 32'hB, 2'b00, 0, 2'b00, 0,     0,     1, 0);
        vecs[1]  = mk(2'b00, 0,     0,     2'b10, 0, 2'b11, 32'hA, 32'hB, 1, 2);
        vecs[2]  = mk(2'b00, 0,     0,     2'b01, 0, 2'b11, 32'hA, 32'hB, 1, 2);
        vecs[3]  = mk(2'b00, 0,     0,     2'b00, 0, 2'b01, 32'hB, 0,     1, 1);
        vecs[4]  = mk(2'b00, 0,     0,     2'b11, 0, 2'b01, 32'hB, 0,     1, 1);
        vecs[5]  = mk(2'b11, 32'hC, 32'hD, 2'b00, 0, 2'b00, 0,     0,     1, 0);
        vecs[6]  = mk(2'b11, 32'hE, 32'hF, 2'b00, 0, 2'b11, 32'hC, 32'hD, 1, 2);
        vecs[7]  = mk(2'b11, 32'h10, 32'h11, 2'b00, 0, 2'b11, 32'hC, 32'hD, 1, 4);
        vecs[8]  = mk(2'b11, 32'h12, 32'h13, 2'b00, 0, 2'b11, 32'hC, 32'hD, 1, 6);
        vecs[9]  = mk(2'b11, 32'h14, 32'h15, 2'b01, 0, 2'b11, 32'hC, 32'hD, 0, 8);
        vecs[10] = mk(2'b11, 32'h14, 32'h15, 2'b00, 0, 2'b11, 32'hD, 32'hE, 0, 7);
        vecs[11] = mk(2'b11, 32'h14, 32'h15, 2'b01, 0, 2'b11, 32'hD, 32'hE, 0, 7);
        vecs[12] = mk(2'b11, 32'h14, 32'h15, 2'b00, 0, 2'b11, 32'hE, 32'hF, 1, 6);
        vecs[13] = mk(2'b00, 0,     0,     2'b11, 0, 2'b11, 32'hE, 32'hF, 0, 8);
        vecs[14] = mk(2'b00, 0,     0,     2'b11, 0, 2'b11, 32'h10, 32'h11, 1, 6);
        vecs[15] = mk(2'b00, 0,     0,     2'b11, 0, 2'b11, 32'h12, 32'h13, 1, 4);
        vecs[16] = mk(2'b00, 0,     0,     2'b11, 0, 2'b11, 32'h14, 32'h15, 1, 2);
        vecs[17] = mk(2'b00, 0,     0,     2'b00, 0, 2'b00, 0,     0,     1, 0);
        vecs[18] = mk(2'b11, 32'h20, 32'h21, 2'b00, 0, 2'b00, 0,   0,     1, 0);
        vecs[19] = mk(2'b11, 32'h22, 32'h23, 2'b00, 0, 2'b11, 32'h20, 32'h21, 1, 2);
        vecs[20] = mk(2'b01, 32'h24, 0,     2'b00, 0, 2'b11, 32'h20, 32'h21, 1, 4);
        vecs[21] = mk(2'b11, 32'h25, 32'h26, 2'b11, 1, 2'b00, 0,   0,     1, 5);
        vecs[22] = mk(2'b00, 0,     0,     2'b00, 0, 2'b00, 0,     0,     1, 0);

        rst = 1'b1;
        drive(2'b00, 0, 0, 2'b00, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #3 check_cycle("reset", 2'b00, 0, 0, 1, 0);

        for (int i = 0; i < 23; i++) begin
            @(posedge clk);
            #1 drive(vecs[i].vld, vecs[i].d0, vecs[i].d1, vecs[i].rdy, vecs[i].fl);
            #3 check_cycle($sformatf("vec%0d", i), vecs[i].ewv, vecs[i].e0, vecs[i].e1,
                           vecs[i].eir, vecs[i].ecnt);
        end

        // Full-rate streaming: head and tail cycle through the 8 slots several times.
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1 drive(2'b11, 32'h100 + 2*c, 32'h101 + 2*c, 2'b11, 0);
            #3;
            if (c == 0) check_cycle("stream0", 2'b00, 0, 0, 1, 0);
            else check_cycle($sformatf("stream%0d", c), 2'b11, 32'h100 + 2*(c-1),
                             32'h101 + 2*(c-1), 1, 2);
        end
        @(posedge clk);
        #1 drive(2'b00, 0, 0, 2'b11, 0);
        #3 check_cycle("stream_tail", 2'b11, 32'h126, 32'h127, 1, 2);
        @(posedge clk);
        #1 drive(2'b00, 0, 0, 2'b00, 0);
        #3 check_cycle("stream_empty", 2'b00, 0, 0, 1, 0);

        // Mid-run reset with count=6 and push/pop offered.
        for (int g = 0; g < 3; g++) begin
            @(posedge clk);
            #1 drive(2'b11, 32'h200 + 2*g, 32'h201 + 2*g, 2'b00, 0);
        end
        @(posedge clk);
        #1 drive(2'b11, 32'h300, 32'h301, 2'b11, 0);
        rst = 1'b1;
        #3 check_cycle("pre_rst", 2'b11, 32'h200, 32'h201, 1, 6);
        @(posedge clk);
        #1 rst = 1'b0;
        drive(2'b00, 0, 0, 2'b00, 0);
        #3 check_cycle("post_rst", 2'b00, 0, 0, 1, 0);
        @(posedge clk);
        #4 check_cycle("post_rst2", 2'b00, 0, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dispatch_buffer.md
DISPATCH_BUFFER -- requirements
Module: dispatch_buffer

Interface
REQ-001 SHALL have parameter QUEUE_SIZE, default 8: entry capacity; power of two and at least 2*IN_WIDTH.
REQ-002 SHALL have parameter IN_WIDTH, default 2: rename-group lanes accepted per cycle.
REQ-003 SHALL have parameter OUT_PORTS, default 2: issue-queue write ports driven per cycle.
REQ-004 SHALL have parameter DATA_TYPE, default logic [31:0]: entry payload type.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 flush_i  input  1  pipeline flush; discards all entries.
REQ-009 in_valid_i  input  IN_WIDTH  per-lane valid; always a contiguous prefix from lane 0.
REQ-010 in_ready_o  output  1  whole group accepted this cycle.
REQ-011 in_data_i  input  IN_WIDTH x DATA_TYPE  lane payloads.
REQ-012 write_valid_o  output  OUT_PORTS  per-port valid toward issue-queue write ports.
REQ-013 write_ready_i  input  OUT_PORTS  per-port ready from issue queue.
REQ-014 write_data_o  output  OUT_PORTS x DATA_TYPE  per-port payload.

Function
REQ-015 SHALL be a circular in-order buffer: head ptr, tail ptr and count registers; ptr width log2(QUEUE_SIZE); count width log2(QUEUE_SIZE)+1; both ptrs wrap modulo QUEUE_SIZE.
REQ-016 in_ready_o SHALL be 1 iff (QUEUE_SIZE - count) >= IN_WIDTH, computed from the registered count only; same-cycle pops give no credit.
REQ-017 Group acceptance SHALL be all-or-nothing: when in_ready_o=1 and any in_valid_i bit is set, write popcount(in_valid_i) lanes at tail..tail+n-1 in lane order.
REQ-018 Port k SHALL present entry head+k (modulo wrap): write_valid_o[k] = (count > k) and not flush_i; write_data_o[k] = that entry.
REQ-019 Pop count SHALL be the length of the leading run of ports with write_valid_o & write_ready_i; port k+1 is not popped when port k is not.
REQ-020 A port with valid high and ready low SHALL hold the same entry next cycle (valid held, data stable).
REQ-021 Latency: an entry accepted in cycle N SHALL first appear on a write port in cycle N+1; no same-cycle bypass.
REQ-022 Simultaneous push and pop SHALL update count by pushed minus popped in one cycle.
REQ-023 Full (count=QUEUE_SIZE): in_ready_o=0, ports valid. Empty (count=0): all write_valid_o=0, in_ready_o=1.
REQ-024 flush_i SHALL zero head, tail and count next cycle, take priority over same-cycle push and pop, and force write_valid_o to 0 in the flush cycle.
REQ-025 in_valid_i that is not a contiguous prefix SHALL be flagged by a simulation assertion; RTL behaviour is then unspecified.

Reset
REQ-026 With rst high at a clk edge, head, tail and count SHALL be 0; rst has priority over flush_i, push and pop.
REQ-027 After reset, write_valid_o SHALL be all 0 and in_ready_o SHALL be 1; write_data_o is don't-care, and the payload array is not reset.
REQ-028 Reset asserted mid-operation SHALL discard all entries within one cycle, with no partial pop.

Structure
REQ-029 Pointer/count width helpers and the default payload typedef SHALL live in the shared scheduler package alongside issue-queue types.
REQ-030 A single sub-module, leading_ones_count (OUT_PORTS-bit vector to count), SHALL compute pop count; push count uses the same module on in_valid_i.
REQ-031 Target size is 120-250 RTL lines; storage is a flop array of QUEUE_SIZE x DATA_TYPE.

Verification
REQ-032 Reset, then push lanes {A,B} with in_valid_i=2'b11 -> next cycle write_valid_o=2'b11, data {A,B}, count=2.
REQ-033 Hold 2 entries with write_ready_i=2'b10 -> no pop, port1 not popped, data unchanged; then ready=2'b01 -> A popped, B moves to port 0.
REQ-034 Push 2 per cycle with ready=0 for 4 cycles (QUEUE_SIZE=8) -> count=8, in_ready_o=0; pop 1 with a push offered -> push rejected, count=7, in_ready_o stays 0 until count<=6.
REQ-035 Run 20 cycles of full-rate push and pop -> head/tail wrap past 7 to 0; output order equals input order.
REQ-036 Assert flush_i with count=5 and push and pop both offered -> write_valid_o=0 that cycle, count=0 next cycle.
REQ-037 Assert rst with count=6 -> next cycle count=0, write_valid_o=0, in_ready_o=1.
